msp430_jtag_user_dr: RTL

// - Fabric-side responder for the BSCAN USER JTAG chain. Consumes the TAP global strobes
//   (TCK/TDI/SEL/CAPTURE/SHIFT/UPDATE/RESET) and drives the user TDO back to the TAP.
// - Oversamples all JTAG inputs in the mclk domain. Implements a DR_WIDTH data register.
// - Hands each UPDATE word to the MSP430 debug logic with a valid/ack handshake.

---
 rtl/msp430_jtag_pkg.sv | 14 +
 rtl/msp430_sync_edge.sv | 47 ++++
 rtl/msp430_jtag_user_dr.sv | 117 +++++++++++
 3 files changed

// File: rtl/msp430_jtag_pkg.sv
// rtl/msp430_jtag_pkg.sv - shared types and constants for the BSCAN USER data register
package msp430_jtag_pkg;

  typedef enum logic {
    UPD_EMPTY   = 1'b0,
    UPD_PENDING = 1'b1
  } upd_state_e;

  localparam int STAT_PEND       = 0;
  localparam int STAT_OVF        = 1;
  localparam int MIN_DR_WIDTH    = 4;
  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/msp430_sync_edge.sv
// rtl/msp430_sync_edge.sv - multi-flop synchronizer with registered rise/fall pulses
module msp430_sync_edge
  import msp430_jtag_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  localparam int FW = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic [FW-1:0]          r_fill;
  logic                   w_armed;
  logic                   w_lvl;

  // Pulses stay quiet until the chain and r_prev hold real pad samples after reset.
  assign w_armed = (r_fill == FW'(SYNC_STAGES + 1));
  assign w_lvl   = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_prev <= w_lvl;
      r_rise <= w_armed & w_lvl & ~r_prev;
      r_fall <= w_armed & ~w_lvl & r_prev;
      if (!w_armed) r_fill <= r_fill + 1'b1;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: rtl/msp430_jtag_user_dr.sv
// rtl/msp430_jtag_user_dr.sv - mclk-domain responder for the BSCAN USER DR chain
module msp430_jtag_user_dr
  import msp430_jtag_pkg::*;
#(
  parameter int DR_WIDTH    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic                jtag_tck,
  input  logic                jtag_tdi,
  input  logic                jtag_sel,
  input  logic                jtag_capture,
  input  logic                jtag_shift,
  input  logic                jtag_update,
  input  logic                jtag_reset,
  output logic                jtag_tdo,
  output logic                jtag_tdo_en,
  input  logic [DR_WIDTH-1:0] cap_data,
  output logic [DR_WIDTH-1:0] upd_data,
  output logic                upd_valid,
  input  logic                upd_ack
);

  localparam int LW = 6;

  logic [SYNC_STAGES-1:0][LW-1:0] r_lvl_sync;
  logic [DR_WIDTH-1:0]            r_sr;
  logic [DR_WIDTH-1:0]            r_upd_data;
  logic                           r_ovf;
  logic                           r_tdo;
  logic                           r_tdo_en;
  upd_state_e                     r_state;

  logic [LW-1:0]       w_lvl;
  logic                w_tdi_s, w_sel_s, w_cap_s, w_shift_s, w_upd_s, w_rst_s;
  logic                w_tck_rise, w_tck_fall;
  logic                w_act, w_cap_edge, w_shift_edge, w_upd_edge, w_pend;
  logic [DR_WIDTH-1:0] w_cap_word;

  msp430_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tck_sync (
    .clk  (mclk),
    .rst  (puc_rst),
    .d    (jtag_tck),
    .rise (w_tck_rise),
    .fall (w_tck_fall)
  );

  always_ff @(posedge mclk) begin
    if (puc_rst) r_lvl_sync <= '0;
    else r_lvl_sync <= {r_lvl_sync[SYNC_STAGES-2:0],
                        {jtag_tdi, jtag_sel, jtag_capture, jtag_shift, jtag_update, jtag_reset}};
  end

  assign w_lvl = r_lvl_sync[SYNC_STAGES-1];
  assign {w_tdi_s, w_sel_s, w_cap_s, w_shift_s, w_upd_s, w_rst_s} = w_lvl;

  // One action per TCK rise: capture beats shift beats update; TLR blocks all of them.
  assign w_act        = w_tck_rise & w_sel_s & ~w_rst_s;
  assign w_cap_edge   = w_act & w_cap_s;
  assign w_shift_edge = w_act & ~w_cap_s & w_shift_s;
  assign w_upd_edge   = w_act & ~w_cap_s & ~w_shift_s & w_upd_s;
  assign w_pend       = (r_state == UPD_PENDING);

  always_comb begin
    w_cap_word            = cap_data;
    w_cap_word[STAT_PEND] = w_pend;
    w_cap_word[STAT_OVF]  = r_ovf;
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_sr       <= '0;
      r_ovf      <= 1'b0;
      r_tdo      <= 1'b0;
      r_tdo_en   <= 1'b0;
      r_upd_data <= '0;
      r_state    <= UPD_EMPTY;
    end else begin
      if (w_rst_s) begin
        r_sr     <= '0;
        r_tdo_en <= 1'b0;
      end else begin
        if (w_cap_edge) r_sr <= w_cap_word;
        else if (w_shift_edge) r_sr <= {w_tdi_s, r_sr[DR_WIDTH-1:1]};
        if (w_tck_fall) begin
          if (w_sel_s && w_shift_s) begin
            r_tdo    <= r_sr[0];
            r_tdo_en <= 1'b1;
          end else begin
            r_tdo_en <= 1'b0;
          end
        end
      end

      if (w_cap_edge) r_ovf <= 1'b0;

      if (r_state == UPD_EMPTY) begin
        if (w_upd_edge) begin
          r_upd_data <= r_sr;
          r_state    <= UPD_PENDING;
        end
      end else begin
        // A same-cycle ack frees the slot, so the new word replaces the old one cleanly.
        if (w_upd_edge && upd_ack) r_upd_data <= r_sr;
        else if (w_upd_edge) r_ovf <= 1'b1;
        else if (upd_ack) r_state <= UPD_EMPTY;
      end
    end
  end

  assign jtag_tdo    = r_tdo;
  assign jtag_tdo_en = r_tdo_en;
  assign upd_data    = r_upd_data;
  assign upd_valid   = w_pend;

endmodule
